// File: rtl/core_bus_arbiter_if.sv
// Bus bundle between the core (instruction and data sides), the arbiter and the memory port.
// The master modport is the arbiter's view. The slave modport is the view of the core and the memory.
interface core_bus_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  instr_flush_i;
  logic                  instr_req_i;
  logic [ADDR_WIDTH-1:0] instr_addr_i;
  logic                  instr_rsp_o;
  logic [31:0]           instr_data_o;

  logic                  data_mem_rd_i;
  logic                  data_mem_wr_i;
  logic [ADDR_WIDTH-1:0] data_addr_i;
  logic [31:0]           data_write_i;
  logic                  data_mem_rsp_o;
  logic [31:0]           data_read_o;

  logic                  mem_rd_o;
  logic                  mem_wr_o;
  logic [ADDR_WIDTH-1:0] mem_addr_o;
  logic [31:0]           mem_wdata_o;
  logic [31:0]           mem_rdata_i;
  logic                  mem_rsp_i;

  modport master (
    input  instr_flush_i, instr_req_i, instr_addr_i,
    output instr_rsp_o, instr_data_o,
    input  data_mem_rd_i, data_mem_wr_i, data_addr_i, data_write_i,
    output data_mem_rsp_o, data_read_o,
    output mem_rd_o, mem_wr_o, mem_addr_o, mem_wdata_o,
    input  mem_rdata_i, mem_rsp_i
  );

  modport slave (
    output instr_flush_i, instr_req_i, instr_addr_i,
    input  instr_rsp_o, instr_data_o,
    output data_mem_rd_i, data_mem_wr_i, data_addr_i, data_write_i,
    input  data_mem_rsp_o, data_read_o,
    input  mem_rd_o, mem_wr_o, mem_addr_o, mem_wdata_o,
    output mem_rdata_i, mem_rsp_i
  );
endinterface

// File: rtl/core_bus_arbiter.sv
// Shares one memory port between instruction fetch and data access. Data has priority.
// A streak limit prevents fetch starvation. A flushed fetch is drained, and its response is discarded.
module core_bus_arbiter #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int ADDR_WIDTH      = 32
) (
  input logic                 clk,
  input logic                 rst_n,
  core_bus_arbiter_if.master  bus
);

  localparam int SW = $clog2(MAX_DATA_STREAK + 1);

  typedef enum logic [1:0] {IDLE, INSTR, DATA, DRAIN} state_t;

  state_t                state;
  logic [SW-1:0]         streak;
  logic                  mem_rd;
  logic                  mem_wr;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;

  logic data_pend;
  logic instr_pend;
  logic streak_full;
  logic grant_data;
  logic grant_instr;

  always_comb begin
    data_pend   = bus.data_mem_rd_i | bus.data_mem_wr_i;
    instr_pend  = bus.instr_req_i & ~bus.instr_flush_i;
    streak_full = (streak == SW'(MAX_DATA_STREAK));
    grant_data  = data_pend & ~(instr_pend & streak_full);
    grant_instr = ~grant_data & instr_pend;
  end

  // NOTE: all state is updated with non-blocking assignments. Every branch then reads the pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      streak    <= '0;
      mem_rd    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_data) begin
            mem_wr    <= bus.data_mem_wr_i;
            mem_rd    <= ~bus.data_mem_wr_i;
            mem_addr  <= bus.data_addr_i;
            mem_wdata <= bus.data_write_i;
            state     <= DATA;
            if (!instr_pend)       streak <= '0;
            else if (!streak_full) streak <= streak + SW'(1);
          end else if (grant_instr) begin
            mem_rd   <= 1'b1;
            mem_wr   <= 1'b0;
            mem_addr <= bus.instr_addr_i;
            state    <= INSTR;
            streak   <= '0;
          end
        end
        DATA, DRAIN: begin
          if (bus.mem_rsp_i) begin
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            state  <= IDLE;
          end
        end
        INSTR: begin
          // A response wins over a flush in the same cycle. Nothing is left to drain.
          if (bus.mem_rsp_i) begin
            mem_rd <= 1'b0;
            mem_wr <= 1'b0;
            state  <= IDLE;
          end else if (bus.instr_flush_i) begin
            state <= DRAIN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_rd_o       = mem_rd;
  assign bus.mem_wr_o       = mem_wr;
  assign bus.mem_addr_o     = mem_addr;
  assign bus.mem_wdata_o    = mem_wdata;

  assign bus.data_mem_rsp_o = (state == DATA) & bus.mem_rsp_i;
  assign bus.data_read_o    = bus.mem_rdata_i;
  assign bus.instr_rsp_o    = (state == INSTR) & bus.mem_rsp_i & ~bus.instr_flush_i;
  assign bus.instr_data_o   = bus.mem_rdata_i;

endmodule

// File: tb/tb_core_bus_arbiter.sv
// Directed testbench for core_bus_arbiter. Expected memory ops and responses are queued when the stimulus is issued.
// Monitors running on the falling edge pop the expected entries and compare them with the DUT outputs.
module tb_core_bus_arbiter;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_INSTR = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd3;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_op_t;

  typedef struct packed {
    logic        chk;
    logic [31:0] data;
  } data_exp_t;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  int   lat   = 2;

  mem_op_t     exp_mem[$];
  logic [31:0] exp_instr[$];
  data_exp_t   exp_data[$];

  core_bus_arbiter_if #(.ADDR_WIDTH(32)) bus ();

  core_bus_arbiter #(.MAX_DATA_STREAK(4), .ADDR_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] addr);
    case (addr)
      32'h0000_0100: return 32'h0050_0093;
      32'h0000_2000: return 32'h1234_5678;
      default:       return {addr[15:0], 16'hC0DE};
    endcase
  endfunction

  // Memory model: responds lat cycles after a strobe is first seen.
  initial begin
    bus.mem_rsp_i   = 1'b0;
    bus.mem_rdata_i = '0;
    forever begin
      @(negedge clk);
      if (rst_n && (bus.mem_rd_o || bus.mem_wr_o)) begin
        repeat (lat) @(posedge clk);
        #1;
        bus.mem_rsp_i   = 1'b1;
        bus.mem_rdata_i = mem_data(bus.mem_addr_o);
        @(posedge clk);
        #1;
        bus.mem_rsp_i   = 1'b0;
        bus.mem_rdata_i = '0;
      end
    end
  end

  logic    strobe_prev = 1'b0;
  mem_op_t cur_op      = '0;

  always @(negedge clk) begin
    if (rst_n && (bus.mem_rd_o || bus.mem_wr_o)) begin
      if (!strobe_prev) begin
        if (exp_mem.size() == 0) begin
          check("mem_unexpected_op", 32'(bus.mem_rd_o | bus.mem_wr_o), 32'd0);
        end else begin
          cur_op = exp_mem.pop_front();
          check("mem_wr", 32'(bus.mem_wr_o), 32'(cur_op.wr));
          check("mem_rd", 32'(bus.mem_rd_o), 32'(!cur_op.wr));
          check("mem_addr", bus.mem_addr_o, cur_op.addr);
          if (cur_op.wr) check("mem_wdata", bus.mem_wdata_o, cur_op.wdata);
        end
      end else begin
        check("mem_addr_held", bus.mem_addr_o, cur_op.addr);
      end
    end
    strobe_prev = bus.mem_rd_o | bus.mem_wr_o;
  end

  always @(negedge clk) begin
    if (rst_n && bus.instr_rsp_o) begin
      if (exp_instr.size() == 0) check("instr_rsp_unexpected", 32'(bus.instr_rsp_o), 32'd0);
      else check("instr_data", bus.instr_data_o, exp_instr.pop_front());
    end
  end

  data_exp_t cur_d;
  always @(negedge clk) begin
    if (rst_n && bus.data_mem_rsp_o) begin
      if (exp_data.size() == 0) begin
        check("data_rsp_unexpected", 32'(bus.data_mem_rsp_o), 32'd0);
      end else begin
        cur_d = exp_data.pop_front();
        if (cur_d.chk) check("data_read", bus.data_read_o, cur_d.data);
      end
    end
  end

  task automatic wait_sig(input string name, input bit is_instr);
    bit seen = 1'b0;
    for (int n = 0; n < 300 && !seen; n++) begin
      @(negedge clk);
      seen = is_instr ? bus.instr_rsp_o : bus.data_mem_rsp_o;
    end
    if (!seen) begin
      total++;
      bad++;
      $display("FAIL %s: no response within 300 cycles", name);
    end
  endtask

  task automatic do_fetch(input logic [31:0] addr);
    bus.instr_addr_i = addr;
    bus.instr_req_i  = 1'b1;
    wait_sig("fetch_timeout", 1'b1);
    @(posedge clk);
    #1;
    bus.instr_req_i = 1'b0;
  endtask

  task automatic do_data(input bit wr, input logic [31:0] addr, input logic [31:0] wdata, input bit keep);
    bus.data_mem_wr_i = wr;
    bus.data_mem_rd_i = !wr;
    bus.data_addr_i   = addr;
    bus.data_write_i  = wdata;
    wait_sig("data_timeout", 1'b0);
    @(posedge clk);
    #1;
    if (!keep) begin
      bus.data_mem_wr_i = 1'b0;
      bus.data_mem_rd_i = 1'b0;
    end
  endtask

  task automatic gap();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.instr_flush_i = 1'b0;
    bus.instr_req_i   = 1'b0;
    bus.instr_addr_i  = '0;
    bus.data_mem_rd_i = 1'b0;
    bus.data_mem_wr_i = 1'b0;
    bus.data_addr_i   = '0;
    bus.data_write_i  = '0;
    rst_n = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_state", 32'(dut.state), 32'(S_IDLE));
    check("rst_streak", 32'(dut.streak), 32'd0);
    check("rst_mem_rd", 32'(bus.mem_rd_o), 32'd0);
    check("rst_mem_wr", 32'(bus.mem_wr_o), 32'd0);
    check("rst_instr_rsp", 32'(bus.instr_rsp_o), 32'd0);
    check("rst_data_rsp", 32'(bus.data_mem_rsp_o), 32'd0);
    check("rst_mem_addr", bus.mem_addr_o, 32'd0);
    check("rst_mem_wdata", bus.mem_wdata_o, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    gap();

    // Single fetch: the strobe rises one cycle after the request, and memory answers three cycles later.
    lat = 3;
    exp_mem.push_back('{wr: 1'b0, addr: 32'h100, wdata: 32'h0});
    exp_instr.push_back(32'h0050_0093);
    bus.instr_addr_i = 32'h100;
    bus.instr_req_i  = 1'b1;
    @(negedge clk);
    check("fetch_mem_rd_grant_cycle", 32'(bus.mem_rd_o), 32'd0);
    @(negedge clk);
    check("fetch_mem_rd_next_cycle", 32'(bus.mem_rd_o), 32'd1);
    wait_sig("fetch1_timeout", 1'b1);
    @(posedge clk);
    #1;
    bus.instr_req_i = 1'b0;
    gap();

    // Simultaneous fetch and store: the store goes first.
    lat = 2;
    exp_mem.push_back('{wr: 1'b1, addr: 32'h1000, wdata: 32'hDEAD_BEEF});
    exp_mem.push_back('{wr: 1'b0, addr: 32'h200, wdata: 32'h0});
    exp_data.push_back('{chk: 1'b0, data: 32'h0});
    exp_instr.push_back(32'h0200_C0DE);
    fork
      do_fetch(32'h200);
      do_data(1'b1, 32'h1000, 32'hDEAD_BEEF, 1'b0);
    join
    gap();

    // Continuous data traffic with a pending fetch: four data ops, then the fetch, then data again.
    lat = 1;
    exp_mem.push_back('{wr: 1'b0, addr: 32'h3000, wdata: 32'h0});
    exp_mem.push_back('{wr: 1'b0, addr: 32'h3004, wdata: 32'h0});
    exp_mem.push_back('{wr: 1'b1, addr: 32'h3008, wdata: 32'h55AA_55AA});
    exp_mem.push_back('{wr: 1'b0, addr: 32'h300C, wdata: 32'h0});
    exp_mem.push_back('{wr: 1'b0, addr: 32'h600, wdata: 32'h0});
    exp_mem.push_back('{wr: 1'b0, addr: 32'h3010, wdata: 32'h0});
    exp_mem.push_back('{wr: 1'b0, addr: 32'h3014, wdata: 32'h0});
    exp_data.push_back('{chk: 1'b1, data: 32'h3000_C0DE});
    exp_data.push_back('{chk: 1'b1, data: 32'h3004_C0DE});
    exp_data.push_back('{chk: 1'b0, data: 32'h0});
    exp_data.push_back('{chk: 1'b1, data: 32'h300C_C0DE});
    exp_data.push_back('{chk: 1'b1, data: 32'h3010_C0DE});
    exp_data.push_back('{chk: 1'b1, data: 32'h3014_C0DE});
    exp_instr.push_back(32'h0600_C0DE);
    fork
      do_fetch(32'h600);
      begin
        do_data(1'b0, 32'h3000, 32'h0, 1'b1);
        do_data(1'b0, 32'h3004, 32'h0, 1'b1);
        do_data(1'b1, 32'h3008, 32'h55AA_55AA, 1'b1);
        do_data(1'b0, 32'h300C, 32'h0, 1'b1);
        do_data(1'b0, 32'h3010, 32'h0, 1'b1);
        do_data(1'b0, 32'h3014, 32'h0, 1'b0);
      end
      begin
        bit seen = 1'b0;
        for (int n = 0; n < 300 && !seen; n++) begin
          @(negedge clk);
          seen = bus.mem_rd_o && (bus.mem_addr_o == 32'h600);
        end
        if (seen) check("streak_after_fetch_grant", 32'(dut.streak), 32'd0);
        else begin
          total++;
          bad++;
          $display("FAIL streak_fetch_grant: fetch never granted");
        end
      end
    join
    gap();

    // Flush one cycle after the fetch grant: the arbiter drains, and the response is dropped.
    lat = 2;
    exp_mem.push_back('{wr: 1'b0, addr: 32'h300, wdata: 32'h0});
    bus.instr_addr_i = 32'h300;
    bus.instr_req_i  = 1'b1;
    @(posedge clk);
    #1;
    bus.instr_flush_i = 1'b1;
    bus.instr_req_i   = 1'b0;
    @(posedge clk);
    #1;
    bus.instr_flush_i = 1'b0;
    @(negedge clk);
    check("flush_state_drain", 32'(dut.state), 32'(S_DRAIN));
    check("flush_mem_rd_held", 32'(bus.mem_rd_o), 32'd1);
    @(negedge clk);
    check("flush_instr_rsp_low", 32'(bus.instr_rsp_o), 32'd0);
    check("flush_mem_rd_at_rsp", 32'(bus.mem_rd_o), 32'd1);
    @(negedge clk);
    check("flush_back_idle", 32'(dut.state), 32'(S_IDLE));
    check("flush_mem_rd_dropped", 32'(bus.mem_rd_o), 32'd0);
    @(posedge clk);
    #1;
    exp_mem.push_back('{wr: 1'b0, addr: 32'h104, wdata: 32'h0});
    exp_instr.push_back(32'h0104_C0DE);
    do_fetch(32'h104);
    gap();

    // Flush in the same cycle as the memory response: the response is suppressed, and no drain follows.
    lat = 2;
    exp_mem.push_back('{wr: 1'b0, addr: 32'h400, wdata: 32'h0});
    bus.instr_addr_i = 32'h400;
    bus.instr_req_i  = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    bus.instr_flush_i = 1'b1;
    bus.instr_req_i   = 1'b0;
    @(negedge clk);
    check("flush_rsp_instr_rsp_low", 32'(bus.instr_rsp_o), 32'd0);
    check("flush_rsp_state_instr", 32'(dut.state), 32'(S_INSTR));
    @(posedge clk);
    #1;
    bus.instr_flush_i = 1'b0;
    @(negedge clk);
    check("flush_rsp_state_idle", 32'(dut.state), 32'(S_IDLE));
    check("flush_rsp_mem_rd", 32'(bus.mem_rd_o), 32'd0);
    @(posedge clk);
    #1;
    gap();

    // A load completes, and then a reset arrives in the middle of a fetch.
    lat = 2;
    exp_mem.push_back('{wr: 1'b0, addr: 32'h2000, wdata: 32'h0});
    exp_data.push_back('{chk: 1'b1, data: 32'h1234_5678});
    do_data(1'b0, 32'h2000, 32'h0, 1'b0);
    gap();
    lat = 5;
    exp_mem.push_back('{wr: 1'b0, addr: 32'h500, wdata: 32'h0});
    bus.instr_addr_i = 32'h500;
    bus.instr_req_i  = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    bus.instr_req_i = 1'b0;
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_state", 32'(dut.state), 32'(S_IDLE));
    check("midrst_streak", 32'(dut.streak), 32'd0);
    check("midrst_mem_rd", 32'(bus.mem_rd_o), 32'd0);
    check("midrst_mem_wr", 32'(bus.mem_wr_o), 32'd0);
    check("midrst_mem_addr", bus.mem_addr_o, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    lat = 2;
    exp_mem.push_back('{wr: 1'b0, addr: 32'h108, wdata: 32'h0});
    exp_instr.push_back(32'h0108_C0DE);
    do_fetch(32'h108);
    gap();

    check("exp_mem_left", 32'(exp_mem.size()), 32'd0);
    check("exp_instr_left", 32'(exp_instr.size()), 32'd0);
    check("exp_data_left", 32'(exp_data.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_bus_arbiter.md
Name: core_bus_arbiter

Overview:
- Shares one memory port between the core's instruction-fetch bus and its data bus, so a single-ported memory or cache can serve the whole core.
- Sits between the core top level and the memory or cache controller.
- Fixed data-first priority, with an anti-starvation limit that guarantees fetch progress.
- Handles instruction-bus flush of an in-flight fetch by draining and discarding its response.

Parameters:
- MAX_DATA_STREAK, 4, max consecutive data grants issued while a fetch is pending before the fetch must be granted (>=1).
- ADDR_WIDTH, 32, address width on all three buses.

Ports:
- clk  input  1  core clock
- rst_n  input  1  asynchronous active-low reset
- instr_flush_i  input  1  core abandons its current fetch
- instr_req_i  input  1  fetch request, held with stable address until instr_rsp_o or flush
- instr_addr_i  input  ADDR_WIDTH  fetch address
- instr_rsp_o  output  1  one-cycle fetch completion pulse
- instr_data_o  output  32  fetch data, valid while instr_rsp_o=1
- data_mem_rd_i  input  1  load request, held until data_mem_rsp_o
- data_mem_wr_i  input  1  store request, held until data_mem_rsp_o
- data_addr_i  input  ADDR_WIDTH  load/store address
- data_write_i  input  32  store data
- data_mem_rsp_o  output  1  one-cycle load/store completion pulse
- data_read_o  output  32  load data, valid while data_mem_rsp_o=1
- mem_rd_o  output  1  memory read, held until mem_rsp_i
- mem_wr_o  output  1  memory write, held until mem_rsp_i
- mem_addr_o  output  ADDR_WIDTH  memory address (registered)
- mem_wdata_o  output  32  memory write data (registered)
- mem_rdata_i  input  32  memory read data, valid with mem_rsp_i
- mem_rsp_i  input  1  memory completion pulse

Behaviour:
- Clocking: one clock domain; reset is asynchronous, active-low, on rst_n.
- Reset values: state=IDLE; streak=0; mem_rd_o, mem_wr_o, instr_rsp_o, data_mem_rsp_o = 0; mem_addr_o, mem_wdata_o = 0.
- FSM states: IDLE, INSTR, DATA, DRAIN.
- IDLE, arbitration each cycle:
  - data_pend = data_mem_rd_i | data_mem_wr_i.
  - instr_pend = instr_req_i & ~instr_flush_i.
  - Grant data if data_pend and not (instr_pend and streak == MAX_DATA_STREAK).
  - Otherwise grant the fetch if instr_pend.
  - Otherwise stay in IDLE.
- Data grant:
  - Next cycle mem_wr_o = data_mem_wr_i and mem_rd_o = ~data_mem_wr_i; a store wins if rd and wr are both high.
  - Address and write data are captured into mem_addr_o / mem_wdata_o.
  - Go to DATA.
  - streak increments (saturating at MAX_DATA_STREAK) if instr_pend; otherwise streak is cleared to 0.
- Fetch grant: next cycle mem_rd_o=1 and mem_addr_o=instr_addr_i; go to INSTR; streak cleared to 0.
- Request latency: the granted request appears on the memory port 1 cycle after grant.
- Holding: mem_rd_o / mem_wr_o and mem_addr_o stay stable until mem_rsp_i.
- DATA:
  - data_mem_rsp_o = mem_rsp_i and data_read_o = mem_rdata_i, combinational pass-through.
  - On mem_rsp_i: deassert the memory strobes, return to IDLE.
- INSTR:
  - instr_rsp_o = mem_rsp_i & ~instr_flush_i; instr_data_o = mem_rdata_i.
  - On mem_rsp_i: return to IDLE.
  - instr_flush_i without mem_rsp_i: go to DRAIN with mem_rd_o still held.
- DRAIN:
  - instr_rsp_o is forced to 0.
  - On mem_rsp_i: the response is discarded and the FSM returns to IDLE.
- Back-to-back: after a response cycle, the next grant is evaluated in IDLE, so there is a minimum 1 idle cycle between memory transactions.
- Unused outputs: data_read_o / instr_data_o are don't-care when their rsp is 0; they may be driven as mem_rdata_i.
- Flush and response in the same INSTR cycle: response suppressed, FSM returns to IDLE (not DRAIN).
- A requester dropping its request while granted is illegal, except the instruction bus via flush.
- mem_rsp_i in IDLE is ignored.
- rst_n mid-transaction: immediate return to IDLE with all strobes 0; in-flight memory ops are the memory's responsibility.

Test Plan:
- Single fetch, addr 0x100, memory responds 3 cycles after mem_rd_o rises with data 0x00500093 -> mem_rd_o high 1 cycle after req; instr_rsp_o one pulse with instr_data_o=0x00500093; data_mem_rsp_o never asserted.
- Simultaneous fetch 0x200 and store addr 0x1000 data 0xDEADBEEF -> store granted first (mem_wr_o=1, mem_wdata_o=0xDEADBEEF), then fetch; exactly one rsp pulse per requester.
- Data held continuously with fetch pending, MAX_DATA_STREAK=4 -> 4 data transactions, then 1 fetch, then data resumes; streak back to 0 after the fetch grant.
- Flush asserted 1 cycle after fetch grant, memory responds 2 cycles later -> FSM in DRAIN; mem_rd_o held until mem_rsp_i; instr_rsp_o stays 0; next request granted after IDLE.
- Flush coincident with mem_rsp_i in INSTR -> instr_rsp_o=0; FSM returns to IDLE, never enters DRAIN.
- Load at 0x2000 returns 0x12345678; rst_n pulsed low mid-fetch -> data_read_o=0x12345678 with data_mem_rsp_o pulse; after reset all strobes 0, streak=0, state=IDLE.
